i2c_slave_rx_ctrl: RTL and testbench

- Byte-level controller for the write-only I2C slave receive path.
- Consumes the SCL edge-detector pulses plus synchronized SCL/SDA levels.
- Detects START and STOP, shifts in the address and data bytes, and matches the 7-bit address.
- Drives ACK/NACK on SDA and hands each received byte to the downstream buffer with a one-cycle valid strobe.

---
 rtl/i2c_slave_rx_ctrl_if.sv | 24 ++
 rtl/i2c_slave_rx_ctrl.sv | 136 +++++++++++++
 tb/tb_i2c_slave_rx_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_rx_ctrl_if.sv
// Bus-side bundle for the I2C slave receive controller: synchronized SCL/SDA
// inputs with edge pulses, downstream buffer handshake and ACK/byte outputs.
interface i2c_slave_rx_ctrl_if;
  logic       rising_edge_found;
  logic       falling_edge_found;
  logic       scl_sync;
  logic       sda_sync;
  logic       buf_full;
  logic       sda_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       busy;

  modport slave (
    input  rising_edge_found, falling_edge_found, scl_sync, sda_sync, buf_full,
    output sda_out, rx_data, rx_valid, overrun, busy
  );

  modport master (
    output rising_edge_found, falling_edge_found, scl_sync, sda_sync, buf_full,
    input  sda_out, rx_data, rx_valid, overrun, busy
  );
endinterface

// File: rtl/i2c_slave_rx_ctrl.sv
// Write-only I2C slave receive controller: START/STOP detection, address match,
// ACK/NACK drive and byte hand-off. Define GENERAL_CALL_EN to also accept 8'h00.
module i2c_slave_rx_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h48
) (
  input  logic                   clk,
  input  logic                   n_rst,
  i2c_slave_rx_ctrl_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    WAIT_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_prev_q;
  logic       sda_out_q, sda_out_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic       busy_q, busy_d;

  logic start_det, stop_det, rise, fall, addr_hit;

  assign start_det = bus.scl_sync & sda_prev_q & ~bus.sda_sync;
  assign stop_det  = bus.scl_sync & ~sda_prev_q & bus.sda_sync;
  // Coincident rise and fall pulses are contradictory, so neither is honoured.
  assign rise = bus.rising_edge_found & ~bus.falling_edge_found;
  assign fall = bus.falling_edge_found & ~bus.rising_edge_found;

`ifdef GENERAL_CALL_EN
  assign addr_hit = (shift_q == {SLAVE_ADDR, 1'b0}) || (shift_q == 8'h00);
`else
  assign addr_hit = (shift_q == {SLAVE_ADDR, 1'b0});
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      sda_prev_q <= 1'b1;
      sda_out_q  <= 1'b1;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      sda_prev_q <= bus.sda_sync;
      sda_out_q  <= sda_out_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    sda_out_d  = sda_out_q;
    rx_valid_d = 1'b0;
    overrun_d  = 1'b0;
    busy_d     = busy_q;

    if (start_det) begin
      bit_cnt_d = 4'd0;
      shift_d   = 8'h00;
      sda_out_d = 1'b1;
      state_d   = ADDR;
    end else if (stop_det) begin
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
      state_d   = IDLE;
    end else begin
      case (state_q)
        ADDR, DATA: begin
          if (rise) begin
            shift_d = {shift_q[6:0], bus.sda_sync};
            if (bit_cnt_q != 4'd8) begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else if (fall && bit_cnt_q == 4'd8) begin
            if (state_q == ADDR) begin
              if (addr_hit) begin
                sda_out_d = 1'b0;
                busy_d    = 1'b1;
                state_d   = ADDR_ACK;
              end else begin
                state_d = WAIT_STOP;
              end
            end else if (!bus.buf_full) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              sda_out_d  = 1'b0;
              state_d    = DATA_ACK;
            end else begin
              overrun_d = 1'b1;
              busy_d    = 1'b0;
              state_d   = WAIT_STOP;
            end
          end
        end
        // SDA stays pulled low through the 9th SCL high and is released on its fall.
        ADDR_ACK, DATA_ACK: begin
          if (fall) begin
            sda_out_d = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = DATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.sda_out  = sda_out_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.overrun  = overrun_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx_ctrl.sv
// Scoreboard bench for i2c_slave_rx_ctrl: directed and random I2C write transfers
// checked against a transaction-level model. Honours GENERAL_CALL_EN like the design.
module tb_i2c_slave_rx_ctrl;
  localparam logic [6:0] SLAVE_ADDR = 7'h48;

  typedef struct packed {
    logic       isOverrun;
    logic [7:0] data;
  } expT;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic masterSda = 1'b1;
  int   errors = 0;
  int   checks = 0;

  expT        expQ[$];
  logic [7:0] modelLastData = 8'h00;
  logic       modelBusy = 1'b0;
  logic       modelAccepting = 1'b0;

  i2c_slave_rx_ctrl_if bus ();

  i2c_slave_rx_ctrl #(.SLAVE_ADDR(SLAVE_ADDR)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Open-drain bus: the line is low if either the master or the slave pulls it.
  assign bus.sda_sync = masterSda & bus.sda_out;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic addressAccepted(input logic [7:0] addrByte);
    logic ok;
    ok = (addrByte[7:1] == SLAVE_ADDR) && (addrByte[0] == 1'b0);
`ifdef GENERAL_CALL_EN
    if (addrByte == 8'h00) ok = 1'b1;
`endif
    return ok;
  endfunction

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setSda(input logic v);
    @(negedge clk);
    masterSda = v;
  endtask

  task automatic sclRise();
    @(negedge clk);
    bus.scl_sync = 1'b1;
    bus.rising_edge_found = 1'b1;
    @(negedge clk);
    bus.rising_edge_found = 1'b0;
  endtask

  task automatic sclFall();
    @(negedge clk);
    bus.scl_sync = 1'b0;
    bus.falling_edge_found = 1'b1;
    @(negedge clk);
    bus.falling_edge_found = 1'b0;
  endtask

  task automatic sendBit(input logic b);
    setSda(b);
    idleCycles(1);
    sclRise();
    idleCycles(2);
    sclFall();
  endtask

  // Eight data bits then the 9th clock, checking the slave's ACK during SCL high.
  task automatic sendByte(input logic [7:0] b, input logic expAck, input string name);
    for (int i = 7; i >= 0; i--) sendBit(b[i]);
    setSda(1'b1);
    idleCycles(1);
    sclRise();
    idleCycles(1);
    checkOutput(name, {31'd0, bus.sda_out}, {31'd0, ~expAck});
    idleCycles(1);
    sclFall();
  endtask

  task automatic startCond();
    setSda(1'b1);
    if (bus.scl_sync == 1'b0) sclRise();
    idleCycles(2);
    setSda(1'b0);
    modelAccepting = 1'b0;
    idleCycles(2);
    sclFall();
  endtask

  task automatic stopCond();
    setSda(1'b0);
    idleCycles(1);
    sclRise();
    idleCycles(2);
    setSda(1'b1);
    modelBusy = 1'b0;
    modelAccepting = 1'b0;
    idleCycles(2);
    checkOutput("busyAfterStop", {31'd0, bus.busy}, 32'd0);
    checkOutput("sdaAfterStop", {31'd0, bus.sda_out}, 32'd1);
  endtask

  task automatic sendAddr(input logic [7:0] addrByte);
    logic ok;
    ok = addressAccepted(addrByte);
    modelAccepting = ok;
    if (ok) modelBusy = 1'b1;
    sendByte(addrByte, ok, "addrAck");
    checkOutput("busyAfterAddr", {31'd0, bus.busy}, {31'd0, modelBusy});
  endtask

  task automatic sendData(input logic [7:0] d, input logic full);
    logic ack;
    ack = 1'b0;
    bus.buf_full = full;
    if (modelAccepting) begin
      if (!full) begin
        expQ.push_back('{isOverrun: 1'b0, data: d});
        modelLastData = d;
        ack = 1'b1;
      end else begin
        expQ.push_back('{isOverrun: 1'b1, data: modelLastData});
        modelAccepting = 1'b0;
        modelBusy = 1'b0;
      end
    end
    sendByte(d, ack, "dataAck");
    checkOutput("busyAfterData", {31'd0, bus.busy}, {31'd0, modelBusy});
    bus.buf_full = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] addrByte, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input int nBytes, input logic [2:0] fullMask);
    startCond();
    sendAddr(addrByte);
    if (nBytes > 0) sendData(d0, fullMask[0]);
    if (nBytes > 1) sendData(d1, fullMask[1]);
    if (nBytes > 2) sendData(d2, fullMask[2]);
    stopCond();
  endtask

  // Monitor: every strobe the DUT presents consumes one expected entry.
  always @(negedge clk) begin : monitor
    expT e;
    if (n_rst && (bus.rx_valid || bus.overrun)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedStrobe", 32'(expQ.size()), 32'd1);
      end else begin
        e = expQ.pop_front();
        checkOutput("strobeKind", {30'd0, bus.overrun, bus.rx_valid},
                    e.isOverrun ? 32'd2 : 32'd1);
        checkOutput("rxData", {24'd0, bus.rx_data}, {24'd0, e.data});
      end
    end
  end

  initial begin
    bus.rising_edge_found  = 1'b0;
    bus.falling_edge_found = 1'b0;
    bus.scl_sync           = 1'b1;
    bus.buf_full           = 1'b0;
    n_rst = 1'b0;
    idleCycles(3);
    checkOutput("resetSda", {31'd0, bus.sda_out}, 32'd1);
    checkOutput("resetRxData", {24'd0, bus.rx_data}, 32'd0);
    checkOutput("resetValid", {31'd0, bus.rx_valid}, 32'd0);
    checkOutput("resetOverrun", {31'd0, bus.overrun}, 32'd0);
    checkOutput("resetBusy", {31'd0, bus.busy}, 32'd0);
    n_rst = 1'b1;
    idleCycles(3);

    // Buffer full on the first data byte: NACK, overrun, rx_data still 00.
    applyStimulus(8'h90, 8'h3C, 8'h00, 8'h00, 1, 3'b001);
    checkOutput("rxDataAfterOverrun", {24'd0, bus.rx_data}, 32'd0);
    // Plain write to own address.
    applyStimulus(8'h90, 8'hA5, 8'h00, 8'h00, 1, 3'b000);
    // Foreign address, trailing byte must be ignored.
    applyStimulus(8'h92, 8'hFF, 8'h00, 8'h00, 1, 3'b000);
    // Read request to own address.
    applyStimulus(8'h91, 8'h00, 8'h00, 8'h00, 0, 3'b000);

    // Repeated START in the middle of a data byte.
    startCond();
    sendAddr(8'h90);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    startCond();
    sendAddr(8'h90);
    sendData(8'h5A, 1'b0);
    stopCond();

    // General call: ACKed only when the feature is built in.
    applyStimulus(8'h00, 8'h11, 8'h00, 8'h00, 1, 3'b000);

    for (int t = 0; t < 14; t++) begin
      logic [7:0] addrByte;
      case ($urandom_range(0, 4))
        0: addrByte = {SLAVE_ADDR, 1'b0};
        1: addrByte = {SLAVE_ADDR, 1'b1};
        2: addrByte = 8'h00;
        3: addrByte = {SLAVE_ADDR ^ 7'(1 << $urandom_range(0, 6)), 1'b0};
        default: addrByte = 8'($urandom);
      endcase
      applyStimulus(addrByte, 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(1, 3)),
                    {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0});
    end

    idleCycles(4);
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

    // Reset while the slave is pulling SDA low for the address ACK.
    startCond();
    for (int i = 7; i >= 0; i--) sendBit(8'h90 >> i);
    setSda(1'b1);
    idleCycles(1);
    sclRise();
    idleCycles(1);
    checkOutput("ackBeforeReset", {31'd0, bus.sda_out}, 32'd0);
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("asyncResetSda", {31'd0, bus.sda_out}, 32'd1);
    checkOutput("asyncResetBusy", {31'd0, bus.busy}, 32'd0);
    checkOutput("asyncResetValid", {31'd0, bus.rx_valid}, 32'd0);
    checkOutput("asyncResetOverrun", {31'd0, bus.overrun}, 32'd0);
    checkOutput("asyncResetRxData", {24'd0, bus.rx_data}, 32'd0);
    modelBusy = 1'b0;
    modelAccepting = 1'b0;
    modelLastData = 8'h00;
    idleCycles(2);
    masterSda = 1'b1;
    bus.scl_sync = 1'b1;
    n_rst = 1'b1;
    idleCycles(3);

    applyStimulus(8'h90, 8'hC3, 8'h00, 8'h00, 1, 3'b000);
    idleCycles(4);
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
